egd_bitstream_feeder: RTL and testbench

- Upstream stage of the exp-Golomb decoder.
- Accepts NAL payload bytes from the host over a valid/ready byte interface and removes H.264 emulation-prevention bytes (0x00 0x00 0x03).
- Keeps a 32-bit MSB-first bit buffer and presents a 16-bit left-aligned window, which feeds the decoder's 16-bit bitstream input.
- The decoder returns how many bits it consumed; the feeder shifts the buffer and refills it.

---
 rtl/egd_bitstream_feeder_if.sv | 21 ++
 rtl/egd_bitstream_feeder.sv | 117 +++++++++++
 tb/tb_egd_bitstream_feeder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/egd_bitstream_feeder_if.sv
// Byte-in / window-out / consume bus of the exp-Golomb bitstream feeder.
// master = host + decoder side, slave = feeder.
interface egd_bitstream_feeder_if;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bs_window;
  logic        win_valid;
  logic        cons_valid;
  logic [4:0]  cons_len;

  modport master (
    output in_byte, in_valid, cons_valid, cons_len,
    input  in_ready, bs_window, win_valid
  );

  modport slave (
    input  in_byte, in_valid, cons_valid, cons_len,
    output in_ready, bs_window, win_valid
  );
endinterface

// File: rtl/egd_bitstream_feeder.sv
// Bitstream feeder for the exp-Golomb decoder: 32-bit MSB-first buffer.
// Define EGD_EPB_REMOVE_EN to drop emulation-prevention bytes (00 00 03).
module egd_bitstream_feeder #(
  parameter int CNT_W = 16,
  parameter int EPB_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  egd_bitstream_feeder_if.slave bus,
  output logic [5:0]           fill_level,
  output logic                 byte_aligned,
  output logic [CNT_W-1:0]     bits_consumed,
  output logic [EPB_W-1:0]     epb_count,
  output logic                 err_underflow
);

  logic [31:0]      buf_q;
  logic [5:0]       fill_q;
  logic [2:0]       bit_off;
  logic [CNT_W-1:0] cons_cnt;
  logic             err_q;

  logic        legal;
  logic        illegal;
  logic [4:0]  c;
  logic [31:0] buf_s;
  logic [5:0]  fill_s;
  logic        push;
  logic        drop;
  logic        ins;
  logic [31:0] buf_n;
  logic [5:0]  fill_n;

  assign bus.in_ready  = ~rst & ~flush & (fill_q <= 6'd24);
  assign bus.bs_window = buf_q[31:16];
  assign bus.win_valid = (fill_q >= 6'd16);

  assign fill_level    = fill_q;
  assign byte_aligned  = (bit_off == 3'd0);
  assign bits_consumed = cons_cnt;
  assign err_underflow = err_q;

  assign legal = bus.cons_valid & bus.win_valid
               & (bus.cons_len != 5'd0)
               & (bus.cons_len <= 5'd16);
  assign illegal = bus.cons_valid & ~legal;

  assign c      = legal ? bus.cons_len : 5'd0;
  assign buf_s  = buf_q << c;
  assign fill_s = fill_q - {1'b0, c};
  assign push   = bus.in_valid & bus.in_ready;
  assign ins    = push & ~drop;

  // Consume first, then append the new byte right below the remaining bits
  always_comb begin
    buf_n  = buf_s;
    fill_n = fill_s;
    if (ins) begin
      buf_n  = buf_s | ({bus.in_byte, 24'b0} >> fill_s);
      fill_n = fill_s + 6'd8;
    end
  end

  // Buffer, fill, alignment and sticky error state
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q    <= '0;
      fill_q   <= '0;
      bit_off  <= '0;
      cons_cnt <= '0;
      err_q    <= 1'b0;
    end else if (flush) begin
      buf_q   <= '0;
      fill_q  <= '0;
      bit_off <= '0;
      err_q   <= 1'b0;
    end else begin
      buf_q    <= buf_n;
      fill_q   <= fill_n;
      bit_off  <= bit_off + c[2:0];
      cons_cnt <= cons_cnt + CNT_W'(c);
      if (illegal) err_q <= 1'b1;
    end
  end

`ifdef EGD_EPB_REMOVE_EN
  logic [1:0]       zero_run;
  logic [EPB_W-1:0] epb_q;

  assign drop = push & (zero_run == 2'd2) & (bus.in_byte == 8'h03);
  assign epb_count = epb_q;

  // Track consecutive zero bytes and count dropped EPBs
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_run <= '0;
      epb_q    <= '0;
    end else if (flush) begin
      zero_run <= '0;
    end else if (push) begin
      if (drop) begin
        zero_run <= '0;
        if (epb_q != {EPB_W{1'b1}}) epb_q <= epb_q + 1'b1;
      end else if (bus.in_byte == 8'h00) begin
        if (zero_run != 2'd2) zero_run <= zero_run + 2'd1;
      end else begin
        zero_run <= '0;
      end
    end
  end
`else
  assign drop = 1'b0;
  assign epb_count = '0;
`endif

endmodule

// File: tb/tb_egd_bitstream_feeder.sv
// Directed bench for egd_bitstream_feeder.
// Honours EGD_EPB_REMOVE_EN for the emulation-prevention case.
module tb_egd_bitstream_feeder;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [5:0]  fill_level;
  logic        byte_aligned;
  logic [15:0] bits_consumed;
  logic [7:0]  epb_count;
  logic        err_underflow;
  int          nvec = 0;
  int          nerr = 0;

  egd_bitstream_feeder_if bus();

  egd_bitstream_feeder #(.CNT_W(16), .EPB_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .bus           (bus),
    .fill_level    (fill_level),
    .byte_aligned  (byte_aligned),
    .bits_consumed (bits_consumed),
    .epb_count     (epb_count),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic consume(input logic [4:0] n);
    bus.cons_valid = 1'b1;
    bus.cons_len   = n;
    step();
    bus.cons_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.in_byte = 8'h00;
    bus.in_valid = 1'b0;
    bus.cons_valid = 1'b0;
    bus.cons_len = 5'd0;
    step();
    step();
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_window", 32'(bus.bs_window), 32'h0);
    check("rst_win_valid", 32'(bus.win_valid), 32'd0);
    check("rst_fill", 32'(fill_level), 32'd0);
    check("rst_aligned", 32'(byte_aligned), 32'd1);
    check("rst_bits", 32'(bits_consumed), 32'd0);
    check("rst_epb", 32'(epb_count), 32'd0);
    check("rst_err", 32'(err_underflow), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus.in_ready), 32'd1);

    push(8'hAB);
    check("load1_window", 32'(bus.bs_window), 32'hAB00);
    check("load1_fill", 32'(fill_level), 32'd8);
    push(8'hCD);
    check("load_window", 32'(bus.bs_window), 32'hABCD);
    check("load_win_valid", 32'(bus.win_valid), 32'd1);
    check("load_fill", 32'(fill_level), 32'd16);
    check("load_ready", 32'(bus.in_ready), 32'd1);

    consume(5'd3);
    check("cons_window", 32'(bus.bs_window), 32'h5E68);
    check("cons_fill", 32'(fill_level), 32'd13);
    check("cons_win_valid", 32'(bus.win_valid), 32'd0);
    check("cons_aligned", 32'(byte_aligned), 32'd0);
    check("cons_bits", 32'(bits_consumed), 32'd3);

    do_flush();
    check("flush1_fill", 32'(fill_level), 32'd0);
    check("flush1_aligned", 32'(byte_aligned), 32'd1);
    check("flush1_bits", 32'(bits_consumed), 32'd3);
    push(8'hAB);
    push(8'hCD);
    bus.in_valid = 1'b1;
    bus.in_byte = 8'h12;
    consume(5'd4);
    bus.in_valid = 1'b0;
    check("sim_window", 32'(bus.bs_window), 32'hBCD1);
    check("sim_fill", 32'(fill_level), 32'd20);
    check("sim_bits", 32'(bits_consumed), 32'd7);

    do_flush();
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    check("full_fill", 32'(fill_level), 32'd32);
    check("full_ready", 32'(bus.in_ready), 32'd0);
    check("full_window", 32'(bus.bs_window), 32'h1122);
    bus.in_valid = 1'b1;
    bus.in_byte = 8'h55;
    step();
    check("bp_fill", 32'(fill_level), 32'd32);
    check("bp_window", 32'(bus.bs_window), 32'h1122);
    consume(5'd8);
    check("bp_cons_fill", 32'(fill_level), 32'd24);
    check("bp_cons_window", 32'(bus.bs_window), 32'h2233);
    check("bp_cons_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
    check("bp_bits", 32'(bits_consumed), 32'd15);

    do_flush();
    push(8'h00);
    push(8'h00);
    push(8'h03);
    push(8'h01);
`ifdef EGD_EPB_REMOVE_EN
    check("epb_fill", 32'(fill_level), 32'd24);
    check("epb_count", 32'(epb_count), 32'd1);
    consume(5'd16);
    check("epb_window", 32'(bus.bs_window), 32'h0100);
    check("epb_cons_fill", 32'(fill_level), 32'd8);
`else
    check("epb_fill", 32'(fill_level), 32'd32);
    check("epb_count", 32'(epb_count), 32'd0);
    consume(5'd16);
    check("epb_window", 32'(bus.bs_window), 32'h0301);
    check("epb_cons_fill", 32'(fill_level), 32'd16);
`endif
    check("epb_bits", 32'(bits_consumed), 32'd31);
    check("epb_aligned", 32'(byte_aligned), 32'd1);

    do_flush();
    push(8'hAA);
    consume(5'd4);
    check("uf_fill", 32'(fill_level), 32'd8);
    check("uf_window", 32'(bus.bs_window), 32'hAA00);
    check("uf_err", 32'(err_underflow), 32'd1);
    check("uf_bits", 32'(bits_consumed), 32'd31);
    step();
    check("uf_sticky", 32'(err_underflow), 32'd1);
    do_flush();
    check("uf_flush_fill", 32'(fill_level), 32'd0);
    check("uf_flush_err", 32'(err_underflow), 32'd0);
    check("uf_flush_bits", 32'(bits_consumed), 32'd31);

    push(8'h5A);
    push(8'hC3);
    consume(5'd17);
    check("len17_err", 32'(err_underflow), 32'd1);
    check("len17_fill", 32'(fill_level), 32'd16);
    do_flush();
    push(8'h5A);
    push(8'hC3);
    consume(5'd0);
    check("len0_err", 32'(err_underflow), 32'd1);
    check("len0_window", 32'(bus.bs_window), 32'h5AC3);
    consume(5'd16);
    check("len16_fill", 32'(fill_level), 32'd0);
    check("len16_window", 32'(bus.bs_window), 32'h0000);
    check("len16_bits", 32'(bits_consumed), 32'd47);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
